// File: rtl/surfer_pkg.sv
// Shared types and default sizing for the surfer frame pipeline.
package surfer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    localparam int MAX_OBS_DEF  = 48;
    localparam int BRAM_LAT_DEF = 2;
    localparam int OBS_GAP_DEF  = 16;

    // Limit the requested obstacle count to what the obstacle memory holds.
    function automatic logic [5:0] clamp_count(input logic [5:0] cnt, input int max_obs);
        if (int'(cnt) > max_obs)
            return 6'(max_obs);
        return cnt;
    endfunction

endpackage

// File: rtl/watchdog_timer.sv
// Counts consecutive enabled cycles; expired flags the last allowed one.
module watchdog_timer #(
    parameter int LIMIT = 1 << 20
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    // Restarts from zero every time enable drops, so each DRAIN gets a full budget.
    always_ff @(posedge clk) begin
        if (rst || !enable)
            count <= '0;
        else if (count != W'(LIMIT - 1))
            count <= count + W'(1);
    end

    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame obstacle issuer: streams obstacle words to the projector and
// handshakes end-of-frame through done_in / proj_done.
module frame_scheduler
    import surfer_pkg::*;
#(
    parameter int MAX_OBS  = MAX_OBS_DEF,
    parameter int BRAM_LAT = BRAM_LAT_DEF,
    parameter int OBS_GAP  = OBS_GAP_DEF,
    parameter int WATCHDOG = 1 << 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [5:0]         obs_count,
    output logic [5:0]         obs_addr,
    input  logic [15:0]        obs_data,
    input  logic signed [15:0] player_height_in,
    input  logic [1:0]         player_lane_in,
    output logic signed [15:0] player_height,
    output logic [1:0]         player_lane,
    output logic [15:0]        obstacle,
    output logic               obstacle_valid,
    output logic               done_in,
    input  logic               proj_done,
    input  logic               triangle_valid,
    output logic [9:0]         tri_count,
    output logic               busy,
    output logic               frame_ready,
    output logic               overrun,
    output logic               timeout
);

    localparam int CW = $clog2(OBS_GAP);

    sched_state_t  state;
    logic [CW-1:0] phase;
    logic [5:0]    idx;
    logic [5:0]    n_obs;
    logic [5:0]    n_clamped;
    logic          wd_enable;
    logic          wd_expired;

    assign n_clamped = clamp_count(obs_count, MAX_OBS);
    assign wd_enable = (state == DRAIN);

    watchdog_timer #(
        .LIMIT(WATCHDOG)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Address is held for the whole slot; the word is captured one cycle after
    // the memory delivers it, so each strobe lands at phase BRAM_LAT+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            phase          <= '0;
            idx            <= '0;
            n_obs          <= '0;
            obs_addr       <= '0;
            obstacle       <= '0;
            obstacle_valid <= 1'b0;
            done_in        <= 1'b0;
            player_height  <= '0;
            player_lane    <= '0;
            tri_count      <= '0;
            busy           <= 1'b0;
            frame_ready    <= 1'b0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            obstacle_valid <= 1'b0;
            frame_ready    <= 1'b0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;

            if (frame_start && state != IDLE)
                overrun <= 1'b1;
            if (triangle_valid && state != IDLE && tri_count != 10'd1023)
                tri_count <= tri_count + 10'd1;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        n_obs         <= n_clamped;
                        player_height <= player_height_in;
                        player_lane   <= player_lane_in;
                        tri_count     <= '0;
                        idx           <= '0;
                        phase         <= '0;
                        obs_addr      <= '0;
                        busy          <= 1'b1;
                        if (n_clamped != 6'd0) begin
                            state <= ISSUE;
                        end else begin
                            state   <= DRAIN;
                            done_in <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (phase == CW'(BRAM_LAT)) begin
                        obstacle       <= obs_data;
                        obstacle_valid <= 1'b1;
                    end
                    if (phase == CW'(OBS_GAP - 1)) begin
                        phase <= '0;
                        if (idx == n_obs - 6'd1) begin
                            state   <= DRAIN;
                            done_in <= 1'b1;
                        end else begin
                            idx      <= idx + 6'd1;
                            obs_addr <= idx + 6'd1;
                        end
                    end else begin
                        phase <= phase + CW'(1);
                    end
                end
                DRAIN: begin
                    if (proj_done) begin
                        state       <= RELEASE;
                        done_in     <= 1'b0;
                        frame_ready <= 1'b1;
                    end else if (wd_expired) begin
                        state   <= RELEASE;
                        done_in <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
